// File: rtl/irq_aggregator.sv
// irq_aggregator: Avalon-MM interrupt controller with synchronized sources, pending/mask
// registers and lowest-index priority. Define IRQ_AGGREGATOR_EDGE_EN to add per-source edge mode.
`timescale 1ns/1ps
module irq_aggregator #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq_out,
  output logic [3:0]         irq_id
);

  // Register bits at NUM_SRC and above are tied to zero through this mask.
  localparam logic [15:0] VALID = 16'((32'd1 << NUM_SRC) - 32'd1);

  logic [NUM_SRC-1:0] s1_r;
  logic [NUM_SRC-1:0] s2_r;
  logic [15:0]        pending_r;
  logic [15:0]        mask_r;
  logic [15:0]        readdata_r;
  logic               irq_out_r;
  logic [3:0]         irq_id_r;

  logic               wr_s;
  logic [15:0]        wdata_s;
  logic [15:0]        w1c_s;
  logic [15:0]        swset_s;
  logic [15:0]        set_s;
  logic [15:0]        pending_s;
  logic [15:0]        masked_s;
  logic [15:0]        rdata_s;
  logic               irq_out_s;
  logic [3:0]         irq_id_s;
  logic               found_s;

`ifdef IRQ_AGGREGATOR_EDGE_EN
  logic [NUM_SRC-1:0] s3_r;
  logic [15:0]        edge_r;
`endif

  function automatic logic [15:0] pad(input logic [NUM_SRC-1:0] v);
    logic [15:0] r;
    r = 16'h0000;
    r[NUM_SRC-1:0] = v;
    return r;
  endfunction

  // Write strobe decode for the write-1 registers.
  always_comb begin
    wr_s    = chipselect & ~write_n;
    wdata_s = writedata & VALID;
    w1c_s   = 16'h0000;
    swset_s = 16'h0000;
    if (wr_s) begin
      case (address)
        3'd1:    w1c_s   = wdata_s;
        3'd5:    swset_s = wdata_s;
        default: begin
          w1c_s   = 16'h0000;
          swset_s = 16'h0000;
        end
      endcase
    end else begin
      w1c_s   = 16'h0000;
      swset_s = 16'h0000;
    end
  end

  // Per-source set condition and next pending value; set and swset beat a same-cycle clear.
  always_comb begin
`ifdef IRQ_AGGREGATOR_EDGE_EN
    set_s = pad(s2_r) & ~(edge_r & pad(s3_r));
`else
    set_s = pad(s2_r);
`endif
    pending_s = (pending_r & ~w1c_s) | set_s | swset_s;
  end

  // Lowest-index priority over the masked pending bits.
  always_comb begin
    masked_s  = pending_r & mask_r;
    irq_out_s = |masked_s;
    irq_id_s  = 4'd0;
    found_s   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (masked_s[i] && !found_s) begin
        irq_id_s = 4'(i);
        found_s  = 1'b1;
      end else begin
        irq_id_s = irq_id_s;
        found_s  = found_s;
      end
    end
  end

  // Read mux, captured every cycle regardless of chipselect.
  always_comb begin
    rdata_s = 16'h0000;
    case (address)
      3'd0:    rdata_s = pad(s2_r);
      3'd1:    rdata_s = pending_r;
      3'd2:    rdata_s = mask_r;
`ifdef IRQ_AGGREGATOR_EDGE_EN
      3'd3:    rdata_s = edge_r;
`endif
      3'd4:    rdata_s = {11'd0, irq_out_r, irq_id_r};
      default: rdata_s = 16'h0000;
    endcase
  end

  // Input synchronizers (plus edge-detect stage when edge mode is built).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= {NUM_SRC{1'b0}};
      s2_r <= {NUM_SRC{1'b0}};
`ifdef IRQ_AGGREGATOR_EDGE_EN
      s3_r <= {NUM_SRC{1'b0}};
`endif
    end else begin
      s1_r <= irq_in;
      s2_r <= s1_r;
`ifdef IRQ_AGGREGATOR_EDGE_EN
      s3_r <= s2_r;
`endif
    end
  end

  // Pending register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= 16'h0000;
    end else begin
      pending_r <= pending_s;
    end
  end

  // Software-written configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r <= 16'h0000;
    end else if (wr_s && (address == 3'd2)) begin
      mask_r <= wdata_s;
    end else begin
      mask_r <= mask_r;
    end
  end

`ifdef IRQ_AGGREGATOR_EDGE_EN
  // Edge-mode select register; changing it never pends a source.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_r <= 16'h0000;
    end else if (wr_s && (address == 3'd3)) begin
      edge_r <= wdata_s;
    end else begin
      edge_r <= edge_r;
    end
  end
`endif

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 16'h0000;
      irq_out_r  <= 1'b0;
      irq_id_r   <= 4'd0;
    end else begin
      readdata_r <= rdata_s;
      irq_out_r  <= irq_out_s;
      irq_id_r   <= irq_id_s;
    end
  end

  assign readdata = readdata_r;
  assign irq_out  = irq_out_r;
  assign irq_id   = irq_id_r;

endmodule

// File: tb/tb_irq_aggregator.sv
// Scoreboard bench for irq_aggregator: expected read values are queued when a read is
// issued and compared when the registered readdata returns.
`timescale 1ns/1ps
module tb_irq_aggregator;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = 16'h0000;
  logic [15:0]   readdata;
  logic [NS-1:0] irq_in = 8'h00;
  logic          irq_out;
  logic [3:0]    irq_id;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] e;
  logic [15:0] g;

  always #5 clk = ~clk;

  irq_aggregator #(.NUM_SRC(NS)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_in(irq_in), .irq_out(irq_out), .irq_id(irq_id)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Queue the expectation, then perform the read and capture the returned data.
  task automatic rd(input logic [2:0] a, input logic [15:0] expv);
    exp_q.push_back(expv);
    address = a; chipselect = 1'b1;
    step(1);
    got_q.push_back(readdata);
    chipselect = 1'b0;
  endtask

  task automatic test_reset;
    irq_in = 8'hFF; reset_n = 1'b0;
    step(3);
    n_tests++; if (readdata !== 16'h0000) begin n_fail++; $display("FAIL reset_readdata: got %h want 0000", readdata); end
    n_tests++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL reset_irq_out: got %b want 0", irq_out); end
    n_tests++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL reset_irq_id: got %0d want 0", irq_id); end
    #2 reset_n = 1'b1;
    step(3);
    rd(3'd1, 16'h00FF);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL reset_pending: got %h want %h", g, e); end
    rd(3'd0, 16'h00FF);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL reset_status: got %h want %h", g, e); end
    rd(3'd2, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL reset_mask: got %h want %h", g, e); end
    n_tests++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL reset_masked_out: got %b want 0", irq_out); end
    irq_in = 8'h00;
    step(3);
    bus_write(3'd1, 16'h00FF);
    rd(3'd1, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL reset_clear: got %h want %h", g, e); end
  endtask

  task automatic test_priority;
    bus_write(3'd2, 16'h000C);
    irq_in = 8'h0C;
    step(3);
    n_tests++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL prio_early: got %b want 0", irq_out); end
    step(1);
    n_tests++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL prio_irq_out: got %b want 1", irq_out); end
    n_tests++; if (irq_id !== 4'd2) begin n_fail++; $display("FAIL prio_irq_id: got %0d want 2", irq_id); end
    rd(3'd4, 16'h0012);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL prio_active: got %h want %h", g, e); end
  endtask

  task automatic test_level_repend;
    bus_write(3'd1, 16'h0004);
    rd(3'd1, 16'h000C);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL level_repend: got %h want %h", g, e); end
    irq_in = 8'h00;
    step(2);
    bus_write(3'd1, 16'h000C);
    step(1);
    n_tests++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL level_clear_out: got %b want 0", irq_out); end
    rd(3'd1, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL level_clear_pend: got %h want %h", g, e); end
  endtask

  task automatic test_edge;
`ifdef IRQ_AGGREGATOR_EDGE_EN
    bus_write(3'd3, 16'h0001);
    bus_write(3'd2, 16'h0001);
    irq_in = 8'h01;
    step(10);
    bus_write(3'd1, 16'h0001);
    rd(3'd1, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL edge_clear: got %h want %h", g, e); end
    step(3);
    rd(3'd1, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL edge_stays_clear: got %h want %h", g, e); end
    irq_in = 8'h00;
    step(3);
    irq_in = 8'h01;
    step(4);
    rd(3'd1, 16'h0001);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL edge_new_rise: got %h want %h", g, e); end
    n_tests++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL edge_irq_out: got %b want 1", irq_out); end
    bus_write(3'd3, 16'h0000);
    bus_write(3'd3, 16'h0001);
    bus_write(3'd1, 16'h0001);
    step(2);
    rd(3'd1, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL edge_mode_switch: got %h want %h", g, e); end
    irq_in = 8'h00;
    bus_write(3'd3, 16'h0000);
    bus_write(3'd2, 16'h0000);
    step(3);
`else
    bus_write(3'd3, 16'hFFFF);
    rd(3'd3, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL edge_absent: got %h want %h", g, e); end
`endif
  endtask

  task automatic test_swset;
    bus_write(3'd2, 16'h0080);
    bus_write(3'd5, 16'h0080);
    step(1);
    n_tests++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL swset_irq_out: got %b want 1", irq_out); end
    n_tests++; if (irq_id !== 4'd7) begin n_fail++; $display("FAIL swset_irq_id: got %0d want 7", irq_id); end
    rd(3'd5, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL swset_reads0: got %h want %h", g, e); end
    irq_in = 8'h40;
    step(3);
    bus_write(3'd1, 16'h00C0);
    rd(3'd1, 16'h0040);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL set_beats_clear: got %h want %h", g, e); end
    n_tests++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL masked_out: got %b want 0", irq_out); end
    bus_write(3'd2, 16'h00C0);
    step(1);
    n_tests++; if (irq_id !== 4'd6 || irq_out !== 1'b1) begin n_fail++; $display("FAIL unmask_id: got %b/%0d want 1/6", irq_out, irq_id); end
  endtask

  task automatic test_back_to_back;
    bus_write(3'd2, 16'h00A5);
    rd(3'd2, 16'h00A5);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL mask_rw: got %h want %h", g, e); end
    bus_write(3'd2, 16'hFFFF);
    rd(3'd2, 16'h00FF);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL mask_upper: got %h want %h", g, e); end
    bus_write(3'd6, 16'hFFFF);
    rd(3'd6, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL addr6: got %h want %h", g, e); end
    rd(3'd7, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL addr7: got %h want %h", g, e); end
    rd(3'd0, 16'h0040);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL status_live: got %h want %h", g, e); end
    bus_write(3'd2, 16'h00C0);
    step(1);
  endtask

  task automatic test_reset_mid;
    n_tests++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL mid_pre_out: got %b want 1", irq_out); end
    address = 3'd2;
    step(1);
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL mid_irq_out: got %b want 0", irq_out); end
    n_tests++; if (readdata !== 16'h0000) begin n_fail++; $display("FAIL mid_readdata: got %h want 0000", readdata); end
    n_tests++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL mid_irq_id: got %0d want 0", irq_id); end
    irq_in = 8'h00;
    step(2);
    reset_n = 1'b1;
    step(4);
    rd(3'd1, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL mid_pending: got %h want %h", g, e); end
    rd(3'd2, 16'h0000);
    e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL mid_mask: got %h want %h", g, e); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_level_repend();
    test_edge();
    test_swset();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_aggregator.md
# irq_aggregator

Avalon-MM slave interrupt controller that sits directly downstream of the interval timer and the other peripheral interrupt sources. It synchronizes up to 16 interrupt request lines and latches them into a pending register. A mask is applied, and the block drives a single registered CPU interrupt plus the ID of the highest-priority active source. Software acknowledges level sources at the source itself, for example by writing the timer's status register; edge-mode sources are acknowledged here.

## Interface
- NUM_SRC, 8: number of interrupt inputs, legal range 1..16. Register bits at index NUM_SRC and above read 0; writes to them are ignored.
- clk  in  1  single clock; every flop in the block is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address of the register being accessed.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe. A write occurs when chipselect=1 and write_n=0.
- writedata  in  16  write data.
- readdata  out  16  registered read data; reset value 0.
- irq_in  in  NUM_SRC  raw, asynchronous interrupt requests, active high.
- irq_out  out  1  registered CPU interrupt; reset value 0.
- irq_id  out  4  index of the lowest-numbered pending and unmasked source; reset value 0.

## Operation
- Synchronizer: each source passes through 2 flops (s1, s2). A third flop s3 captures s2 for edge detection. All three reset to 0.
- Set condition per source: level mode sets on s2=1; edge mode sets on s2=1 and s3=0.
- Register map:
  - 0 STATUS (read-only): s2, the current synchronized input levels.
  - 1 PENDING (read; write-1-to-clear): reset value 0.
  - 2 MASK (read/write): 1 enables the source; reset value 0.
  - 3 EDGE (read/write): 1 selects rising-edge mode; reset value 0.
  - 4 ACTIVE (read-only): bit 4 = irq_out, bits 3:0 = irq_id.
  - 5 SWSET (write-only, reads 0): each 1 bit sets the corresponding pending bit.
  - 6 and 7: read 0; writes are ignored.
- Pending update every cycle: pending <= (pending & ~w1c) | set | swset.
  - Set and swset both win over a same-cycle clear.
  - A level source that is still asserted therefore re-pends immediately after a clear.
- Priority: lowest index wins. With nothing active, irq_id=0 and irq_out=0.
- irq_out and irq_id are computed from (pending & mask) and registered, giving 1 cycle of latency after pending.
- Changing MASK or EDGE never generates an event. s3 updates regardless of mode, so switching a high source to edge mode does not pend it.
- Masking a source keeps its pending bit; only the output is gated.

## Timing
- readdata <= mux(address) on every clock, independent of chipselect. Read latency is 1 cycle and there are no wait states.
- Writes take effect at the clock edge on which the write is sampled. A read of the same register on the next cycle returns the new value.
- Input path: irq_in first sampled high at edge N.
  - s2=1 at edge N+1.
  - pending=1 at edge N+2.
  - irq_out=1 and irq_id valid at edge N+3.
- Clear path: a W1C of the only pending source at edge M gives irq_out=0 at edge M+1, provided the source is no longer set.
- Reset asserted mid-operation clears all flops immediately, including synchronizers, pending, mask, edge and outputs. No event is generated when reset is released.
- Pulses on irq_in shorter than one clk period may be missed. Sources must hold their requests for at least 2 cycles.

## Configuration
- IRQ_AGGREGATOR_EDGE_EN defined:
  - EDGE register at address 3 is present.
  - The s3 flops and per-source edge-mode selection are built.
- IRQ_AGGREGATOR_EDGE_EN undefined:
  - All sources are level-sensitive.
  - The s3 flops are removed.
  - Address 3 reads 0 and writes to it are ignored.

## Test plan
- Reset behaviour: hold reset_n=0 with irq_in=8'hFF, then release. Required: readdata=0, irq_out=0, irq_id=0. After 3 cycles, PENDING reads 8'hFF, MASK reads 0, and irq_out stays 0.
- Priority and latency: MASK=8'h0C, raise irq_in[3] and irq_in[2] together at edge N. Required: irq_out=1 with irq_id=2 at edge N+3, and ACTIVE reads 16'h0012.
- Level re-pend:
  - With irq_in[2] held high, W1C 8'h04. Required: PENDING[2] reads 1 on the next read.
  - Drop irq_in[2], wait 2 cycles, W1C again. Required: pending bit cleared and irq_out=0 one cycle after the write.
- Edge mode (macro defined):
  - EDGE=8'h01, MASK=8'h01, hold irq_in[0] high for 10 cycles, then W1C 8'h01. Required: PENDING[0]=0, and it stays 0 until the next 0-to-1 transition.
  - Writing EDGE=8'h01 while irq_in[0] is already high does not pend the source.
- Software set vs clear: write SWSET=8'h80 (MASK=8'h80). Required: irq_id=7 and irq_out=1 two edges after the write. A same-cycle set and W1C of a bit leaves that bit pending.
- Reset mid-operation: assert reset_n low while irq_out=1. Required: irq_out and readdata go to 0 immediately, without waiting for a clock edge.
